// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// negate_if works on a 64-bit container, so WIDTH is limited to 64.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 12;
  localparam int NEG_W         = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  // Two's-complement negate when neg is set; callers truncate back to WIDTH.
  function automatic logic [NEG_W-1:0] negate_if(input logic [NEG_W-1:0] v, input logic neg);
    return neg ? (~v + NEG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between a requester (master) and the divider (slave).
//
// Handshake: the divider takes an operation on a rising edge where start is
// high and it is either in IDLE, or in DONE with ack also high. Operands and
// is_signed are sampled on that edge only. done stays high with stable
// results until an edge with ack high; start without ack is ignored then.
interface seq_divider_if #(parameter int WIDTH = 12);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, is_signed, dividend, divisor, ack,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, is_signed, dividend, divisor, ack,
    output busy, done, quotient, remainder, div_zero, overflow
  );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {P, A} left, trial-subtract B from P.
// a_next leaves bit 0 clear; the caller inserts q_bit there.
module div_restore_step #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p_next,
  output logic [WIDTH-1:0] a_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {p, a[WIDTH-1]};
    q_bit   = (shifted >= {1'b0, b});
    // P < B before the shift, so a successful trial always fits in WIDTH bits.
    diff    = WIDTH'(shifted - {1'b0, b});
    p_next  = q_bit ? diff : shifted[WIDTH-1:0];
    a_next  = {a[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with optional
// signed (truncating) mode, divide-by-zero and signed-overflow flags.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus,
  output state_t       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvs_q;
  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             sgn_q, q_neg_q, r_neg_q;
  logic             div_zero_q, overflow_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, dvd_neg, dvs_neg, is_zero, is_ovf, last_iter;
  logic [WIDTH-1:0] p_step, a_step;
  logic             q_bit;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .a      (a_q),
    .b      (b_q),
    .p_next (p_step),
    .a_next (a_step),
    .q_bit  (q_bit)
  );

  always_comb begin
    accept    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE && bus.ack));
    dvd_neg   = sgn_q && dvd_q[WIDTH-1];
    dvs_neg   = sgn_q && dvs_q[WIDTH-1];
    is_zero   = (dvs_q == '0);
    is_ovf    = sgn_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // Special cases skip ITER but still pass through FIX so their results are
  // registered on the same path as normal ones.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_PREP;
      ST_PREP: state_d = (is_zero || is_ovf) ? ST_FIX : ST_ITER;
      ST_ITER: if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        if (accept)       state_d = ST_PREP;
        else if (bus.ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      sgn_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dvd_q      <= bus.dividend;
        dvs_q      <= bus.divisor;
        sgn_q      <= SIGNED_EN && bus.is_signed;
        div_zero_q <= 1'b0;
        overflow_q <= 1'b0;
      end
      case (state_q)
        ST_PREP: begin
          cnt_q <= '0;
          b_q   <= WIDTH'(negate_if(NEG_W'(dvs_q), dvs_neg));
          if (is_zero) begin
            a_q        <= '1;
            p_q        <= dvd_q;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b1;
          end else if (is_ovf) begin
            a_q        <= {1'b1, {(WIDTH-1){1'b0}}};
            p_q        <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            overflow_q <= 1'b1;
          end else begin
            a_q     <= WIDTH'(negate_if(NEG_W'(dvd_q), dvd_neg));
            p_q     <= '0;
            q_neg_q <= dvd_neg ^ dvs_neg;
            r_neg_q <= dvd_neg;
          end
        end
        ST_ITER: begin
          p_q   <= p_step;
          a_q   <= a_step | WIDTH'(q_bit);
          cnt_q <= cnt_q + CW'(1);
        end
        ST_FIX: begin
          quot_q <= WIDTH'(negate_if(NEG_W'(a_q), q_neg_q));
          rem_q  <= WIDTH'(negate_if(NEG_W'(p_q), r_neg_q));
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.overflow  = overflow_q;
  assign dbg_state     = state_q;

endmodule
